// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer: takes words over valid/ready and writes each one
// into a transparent latch bank. The enable pulse has a programmable setup,
// open and hold window and comes straight from a flop.
// Optional build macro: LATCH_READBACK_EN adds a latch readback compare with
// a sticky error flag (ports lat_q, err, err_clr).
module latch_write_sequencer #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] lat_d,
    output logic             lat_en,
    output logic             busy,
    output logic             done
`ifdef LATCH_READBACK_EN
    ,
    input  logic [WIDTH-1:0] lat_q,
    input  logic             err_clr,
    output logic             err
`endif
);

    localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_C  = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_OPEN  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] lat_d_q;
    logic             lat_en_q;
    logic             done_q, done_d;
    logic             accept;

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign lat_d    = lat_d_q;
    assign lat_en   = lat_en_q;
    assign done     = done_q;

    // Next-state and window counter: each phase loads its length minus one
    // and advances when the counter reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_OPEN;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_OPEN: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    // State, counter and done pulse; reset drops everything at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Enable is decoded from the next state into a flop so it cannot glitch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lat_en_q <= 1'b0;
        else       lat_en_q <= (state_d == ST_OPEN);
    end

    // Data bus only loads on accept and keeps the last word afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       lat_d_q <= '0;
        else if (accept) lat_d_q <= in_data;
    end

`ifdef LATCH_READBACK_EN
    logic err_q;
    logic rb_mismatch;

    // First HOLD cycle: enable already closed, the latch must hold lat_d.
    assign rb_mismatch = (state_q == ST_HOLD) && (cnt_q == HOLD_LD) && (lat_q != lat_d_q);
    assign err         = err_q;

    // Sticky error; a new mismatch wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)            err_q <= 1'b0;
        else if (rb_mismatch) err_q <= 1'b1;
        else if (err_clr)     err_q <= 1'b0;
    end
`endif

endmodule

// File: doc/latch_write_sequencer.md
Name: latch_write_sequencer

Overview:
Upstream driver for a transparent D-latch bank. It accepts data words over a valid/ready handshake and presents each word on the latch data bus. It then generates a single glitch-free, registered enable pulse with programmable setup, open and hold windows, so the latch captures cleanly. Its outputs connect directly to the latch's d and en inputs.

Parameters:
WIDTH, 8, data word width in bits (>=1)
SETUP_CYC, 1, cycles lat_d is stable with lat_en low before the enable opens (>=1)
PULSE_CYC, 2, cycles lat_en is held high (>=1)
HOLD_CYC, 1, cycles lat_d is held with lat_en low after the enable closes (>=1)

Ports:
clk  input  1  single clock, rising-edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  sequencer can accept a word; high exactly when state is IDLE
in_data  input  WIDTH  upstream word
lat_d  output  WIDTH  to latch d; registered
lat_en  output  1  to latch en; registered, glitch-free
busy  output  1  high in SETUP, OPEN and HOLD
done  output  1  one-cycle pulse marking completion of a write

Behaviour:
- Clock and reset: one clock clk. Reset rstn is asynchronous and active-low.
- Reset state: state=IDLE, lat_d=0, lat_en=0, busy=0, done=0, counter=0.
- States: IDLE, SETUP, OPEN, HOLD.
- Down-counter width: clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1). No wrap is possible.
- Accept: in_valid && in_ready at a rising edge.
  - lat_d <= in_data, state -> SETUP, counter <= SETUP_CYC-1.
  - in_data is sampled only on that edge.
- SETUP: lat_en=0. When counter==0: state -> OPEN, counter <= PULSE_CYC-1. Otherwise decrement.
- OPEN: lat_en=1 for exactly PULSE_CYC cycles. When counter==0: state -> HOLD, counter <= HOLD_CYC-1.
- HOLD: lat_en=0. When counter==0: state -> IDLE and done <= 1 for one cycle (the first IDLE cycle).
- lat_en is a flop output decoded from the next state, so it cannot glitch.
- lat_d changes only on accept. It is never cleared in IDLE; it keeps the last word.
- Timing: first lat_en-high cycle is SETUP_CYC+1 cycles after the accept edge.
- Back-to-back:
  - in_ready is high in the done cycle, so a new word may be accepted there.
  - Minimum accept-to-accept spacing is SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
- in_valid while busy: ignored; the upstream holds the word until in_ready.
- Reset mid-operation: all outputs return to reset values immediately, asynchronously. lat_en falls without waiting for HOLD. No done pulse is produced.
- No X propagation: in_data is not registered unless the word is accepted.

Optional Feature:
Macro LATCH_READBACK_EN.
- Defined:
  - Adds ports lat_q (input, WIDTH, from latch q), err (output, 1) and err_clr (input, 1).
  - lat_q is compared with lat_d in the first HOLD cycle (enable already closed, latch holding).
  - A mismatch sets err on the next edge. err is sticky.
  - err_clr synchronously clears err. If set and clear coincide, set wins.
  - err resets to 0.
- Not defined: these ports and all related logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then idle 5 cycles -> lat_d=0, lat_en=0, busy=0, done=0, in_ready=1.
- Defaults; accept 0xA5 at edge T -> lat_d=0xA5 from T+1; lat_en high at T+2..T+3, low at T+4; done pulse at T+5 with in_ready=1.
- Hold in_valid high with words 0x11 then 0x22 -> 0x22 accepted in 0x11's done cycle; accept spacing = 5 cycles; lat_d never changes while lat_en=1.
- Word 0x3C accepted; rstn pulsed low mid-OPEN (asynchronous, between edges) -> lat_en and lat_d drop to 0 before the next edge; no done pulse; in_ready=1 after release.
- SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2; accept 0xFF at T -> lat_en high only at T+4; done at T+7.
- LATCH_READBACK_EN: lat_q tied to lat_d, write 0x55 -> err=0. Force lat_q=0x54 in HOLD -> err=1 and stays 1. Assert err_clr in the same cycle as another mismatch -> err remains 1. Clear with matching q -> err=0.
